// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizing
// constants and the clear/run state encoding.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;
  localparam int NREAD_DEFAULT = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle of the multi-port register file: read ports, writeback port,
// scoreboard allocation port and the ready indication.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NREAD = NREAD_DEFAULT
);
  localparam int AW = $clog2(NREGS);

  logic                  ready;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  alloc_en;
  logic [AW-1:0]         alloc_addr;

  modport master (
    input  ready, rd_data, rd_busy,
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending bit per architectural register.
// Allocation sets a bit, an accepted writeback clears it; when both hit the
// same register in one cycle the allocation wins. Register 0 never goes busy.
module regfile_scoreboard #(
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [$clog2(NREGS)-1:0] set_addr,
  input  logic                     clr_en,
  input  logic [$clog2(NREGS)-1:0] clr_addr,
  output logic [NREGS-1:0]         busy
);

  logic [NREGS-1:0] busy_d;

  // Next busy vector: clear first so a same-register set overrides it
  always_comb begin
    busy_d = busy;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy state register
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_d;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with scoreboard and a post-reset clear sequence.
// After reset the array is zeroed one entry per cycle; only then is ready
// raised and traffic accepted. Register 0 is hard-wired to zero.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to reads;
// without it a read sees the pre-write array value.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NREAD = NREAD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  state_t                state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic                  ready;
  logic                  clr_last;
  logic                  wr_acc;
  logic                  alloc_acc;
  logic [NREGS-1:0]      busy;
  logic [XLEN-1:0]       mem [NREGS];
  logic [NREAD*XLEN-1:0] rd_data_v;
  logic [NREAD-1:0]      rd_busy_v;

  assign ready     = (state_q == RUN);
  assign clr_last  = (clr_cnt_q == AW'(NREGS - 1));
  assign wr_acc    = bus.wr_en & ready & (bus.wr_addr != '0);
  assign alloc_acc = bus.alloc_en & ready & (bus.alloc_addr != '0);

  // Clear FSM state and counter; reset restarts the clear from index 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: walk the counter to the last index, then hold it there in RUN
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_last) state_d   = RUN;
        else          clr_cnt_d = clr_cnt_q + 1'b1;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Data array: zeroed by the clear walk, written by accepted writebacks
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)  mem[clr_cnt_q]   <= '0;
    else if (wr_acc)       mem[bus.wr_addr] <= bus.wr_data;
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (alloc_acc),
    .set_addr (bus.alloc_addr),
    .clr_en   (wr_acc),
    .clr_addr (bus.wr_addr),
    .busy     (busy)
  );

  // Independent read muxes; outputs held at zero until the clear completes
  always_comb begin
    rd_data_v = '0;
    rd_busy_v = '0;
    for (int i = 0; i < NREAD; i++) begin
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] val;
      addr = bus.rd_addr[i*AW +: AW];
      val  = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_acc && (bus.wr_addr == addr)) val = bus.wr_data;
`endif
      if (!ready || (addr == '0)) val = '0;
      rd_data_v[i*XLEN +: XLEN] = val;
      rd_busy_v[i]              = ready & busy[addr];
    end
  end

  assign bus.ready   = ready;
  assign bus.rd_data = rd_data_v;
  assign bus.rd_busy = rd_busy_v;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (four read ports, default width and depth): reset and
// clear timing, a vector table of write/read/scoreboard cases, a mid-clear
// reset sequence and randomized traffic against a reference model.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NREAD = 4;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: clear progress, register contents, pending set
  int               m_clr = 0;
  logic [XLEN-1:0]  m_mem [NREGS];
  logic [NREGS-1:0] m_busy;

  always @(posedge clk) begin
    if (rst) begin
      m_clr  <= 0;
      m_busy <= '0;
    end else if (m_clr < NREGS) begin
      m_clr <= m_clr + 1;
      if (m_clr == NREGS - 1)
        for (int k = 0; k < NREGS; k++) m_mem[k] <= '0;
    end else begin
      if (bus.wr_en && bus.wr_addr != 0) begin
        m_mem[bus.wr_addr]  <= bus.wr_data;
        m_busy[bus.wr_addr] <= 1'b0;
      end
      if (bus.alloc_en && bus.alloc_addr != 0)
        m_busy[bus.alloc_addr] <= 1'b1;
    end
  end

  function automatic logic m_ready();
    return m_clr == NREGS;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(logic [AW-1:0] a);
    if (!m_ready() || a == 0) return '0;
    if (BYP && bus.wr_en && bus.wr_addr == a) return bus.wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(logic [AW-1:0] a);
    return m_ready() ? m_busy[a] : 1'b0;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit we, input int wa, input logic [XLEN-1:0] wd,
                       input bit ae, input int aa);
    rst            = r;
    bus.wr_en      = we;
    bus.wr_addr    = AW'(wa);
    bus.wr_data    = wd;
    bus.alloc_en   = ae;
    bus.alloc_addr = AW'(aa);
  endtask

  task automatic rd_all(input int a);
    for (int i = 0; i < NREAD; i++) bus.rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model(input string name);
    for (int i = 0; i < NREAD; i++) begin
      chk({name, "_rd"}, bus.rd_data[i*XLEN +: XLEN], exp_rd(bus.rd_addr[i*AW +: AW]));
      chk({name, "_busy"}, XLEN'(bus.rd_busy[i]), XLEN'(exp_busy(bus.rd_addr[i*AW +: AW])));
    end
    chk({name, "_ready"}, XLEN'(bus.ready), XLEN'(m_ready()));
  endtask

  typedef struct {
    bit              we;
    int              wa;
    logic [XLEN-1:0] wd;
    bit              ae;
    int              aa;
    int              ra;
    logic [XLEN-1:0] exp_nb;
    logic [XLEN-1:0] exp_by;
    bit              exp_busy;
  } vec_t;

  vec_t tbl[$];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int n;
    drive(1'b1, 1'b0, 0, '0, 1'b0, 0);
    rd_all(0);
    @(negedge clk);
    step();
    rst = 1'b0;

    // Clear phase: ready low for exactly NREGS cycles, traffic ignored
    for (int i = 0; i < NREGS; i++) begin
      drive(1'b0, 1'b1, 5, 64'hBAD, 1'b1, 5);
      rd_all(i);
      #1;
      chk("clear_ready", XLEN'(bus.ready), '0);
      chk("clear_rd", bus.rd_data[0 +: XLEN], '0);
      chk("clear_busy", XLEN'(bus.rd_busy), '0);
      step();
    end
    drive(1'b0, 1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("ready_after_clear", XLEN'(bus.ready), 1);
    step();
    for (int c = 0; c < NREGS / NREAD; c++) begin
      for (int i = 0; i < NREAD; i++) bus.rd_addr[i*AW +: AW] = AW'(c * NREAD + i);
      #1;
      for (int i = 0; i < NREAD; i++) begin
        chk("post_clear_rd", bus.rd_data[i*XLEN +: XLEN], '0);
        chk("post_clear_busy", XLEN'(bus.rd_busy[i]), '0);
      end
      step();
    end

    // Vector table: writes, reg0, same-cycle forwarding, scoreboard rules
    tbl.push_back('{1, 5, 64'h1234, 0, 0, 5, 64'h0,    64'h1234, 0});
    tbl.push_back('{0, 0, 64'h0,    0, 0, 5, 64'h1234, 64'h1234, 0});
    tbl.push_back('{1, 0, 64'hFF,   0, 0, 0, 64'h0,    64'h0,    0});
    tbl.push_back('{0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    0});
    tbl.push_back('{1, 7, 64'h11,   0, 0, 7, 64'h0,    64'h11,   0});
    tbl.push_back('{1, 7, 64'hAA,   0, 0, 7, 64'h11,   64'hAA,   0});
    tbl.push_back('{0, 0, 64'h0,    0, 0, 7, 64'hAA,   64'hAA,   0});
    tbl.push_back('{0, 0, 64'h0,    1, 3, 3, 64'h0,    64'h0,    0});
    tbl.push_back('{1, 3, 64'h33,   0, 0, 3, 64'h0,    64'h33,   1});
    tbl.push_back('{0, 0, 64'h0,    0, 0, 3, 64'h33,   64'h33,   0});
    tbl.push_back('{1, 3, 64'h44,   1, 3, 3, 64'h33,   64'h44,   0});
    tbl.push_back('{0, 0, 64'h0,    0, 0, 3, 64'h44,   64'h44,   1});
    tbl.push_back('{0, 0, 64'h0,    1, 0, 0, 64'h0,    64'h0,    0});
    tbl.push_back('{0, 0, 64'h0,    0, 0, 0, 64'h0,    64'h0,    0});
    tbl.push_back('{1, 3, 64'h55,   0, 0, 3, 64'h44,   64'h55,   1});
    tbl.push_back('{1, 9, 64'h55,   0, 0, 3, 64'h55,   64'h55,   0});
    tbl.push_back('{0, 0, 64'h0,    0, 0, 9, 64'h55,   64'h55,   0});
    foreach (tbl[v]) begin
      drive(1'b0, tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].ae, tbl[v].aa);
      rd_all(tbl[v].ra);
      #1;
      for (int i = 0; i < NREAD; i++) begin
        chk($sformatf("vec%0d_rd%0d", v, i), bus.rd_data[i*XLEN +: XLEN],
            BYP ? tbl[v].exp_by : tbl[v].exp_nb);
        chk($sformatf("vec%0d_busy%0d", v, i), XLEN'(bus.rd_busy[i]), XLEN'(tbl[v].exp_busy));
      end
      step();
    end

    // Reset part-way through a clear, with writes pulsed during the clear
    drive(1'b0, 1'b1, 12, 64'h77, 1'b0, 0);
    #1;
    step();
    drive(1'b1, 1'b0, 0, '0, 1'b0, 0);
    step();
    drive(1'b0, 1'b1, 12, 64'hDEAD, 1'b1, 12);
    rd_all(12);
    for (int i = 0; i < 10; i++) step();
    drive(1'b1, 1'b1, 12, 64'hDEAD, 1'b1, 12);
    step();
    rst = 1'b0;
    n = 0;
    #1;
    while (!bus.ready && n < 40) begin
      chk("midclear_rd", bus.rd_data[0 +: XLEN], '0);
      step();
      #1;
      n++;
    end
    chk("midclear_ready_latency", XLEN'(n), XLEN'(NREGS));
    drive(1'b0, 1'b0, 0, '0, 1'b0, 0);
    #1;
    chk("midclear_reg12", bus.rd_data[0 +: XLEN], '0);
    chk("midclear_busy12", XLEN'(bus.rd_busy[0]), '0);
    step();

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      drive(($urandom % 200) == 0, $urandom % 2, $urandom % 8, {$urandom, $urandom},
            $urandom % 2, $urandom % 8);
      for (int i = 0; i < NREAD; i++)
        bus.rd_addr[i*AW +: AW] = AW'(($urandom % 4 == 0) ? $urandom % NREGS : $urandom % 8);
      #1;
      check_model("rand");
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 64: data width in bits.
REQ-002 Parameter NREGS, default 32: number of architectural registers; power of two, at least 4.
REQ-003 Parameter NREAD, default 2: number of read ports, 1 to 4.
REQ-004 Derived constant AW = log2(NREGS): width of each register address.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ready  out  1  high when the clear sequence is complete and the block accepts traffic.
REQ-008 rd_addr  in  NREAD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-009 rd_data  out  NREAD*XLEN  packed read data; combinational from rd_addr.
REQ-010 rd_busy  out  NREAD  scoreboard busy bit of each addressed register.
REQ-011 wr_en  in  1  writeback strobe.
REQ-012 wr_addr  in  AW  writeback destination register.
REQ-013 wr_data  in  XLEN  writeback value.
REQ-014 alloc_en  in  1  issue strobe; marks the destination register as pending.
REQ-015 alloc_addr  in  AW  destination register being allocated.

Function
REQ-016 Register 0 SHALL read as zero at all times; writes and allocs to register 0 SHALL be ignored, and its busy bit SHALL always read 0.
REQ-017 A write SHALL update the array at the clock edge where wr_en=1, ready=1 and wr_addr!=0.
REQ-018 A read SHALL be combinational; each port SHALL be independent, and any number of ports MAY address the same register.
REQ-019 Each busy bit SHALL be set at the edge where alloc_en=1 and ready=1 for its register.
REQ-020 Each busy bit SHALL be cleared at the edge where an accepted write targets its register.
REQ-021 If alloc and write target the same register in the same cycle, the data SHALL be written and the busy bit SHALL end set (alloc wins).
REQ-022 rd_busy SHALL reflect the registered busy state and SHALL NOT be bypassed.
REQ-023 The FSM SHALL have the states CLEAR and RUN.
REQ-024 In CLEAR, a counter SHALL zero one register per cycle, starting at index 0 and incrementing.
REQ-025 The FSM SHALL move CLEAR to RUN after the cycle that clears index NREGS-1, so the clear takes exactly NREGS cycles.
REQ-026 The clear counter SHALL saturate and SHALL NOT wrap.
REQ-027 ready SHALL be 1 only in RUN.
REQ-028 While ready=0, wr_en and alloc_en SHALL be ignored, and every rd_data SHALL be 0 and every rd_busy SHALL be 0.
REQ-029 rst asserted in any state, including mid-clear, SHALL restart the clear from index 0.

Reset
REQ-030 At the edge where rst=1, the state SHALL become CLEAR, the counter SHALL become 0, all busy bits SHALL become 0 and ready SHALL become 0.
REQ-031 After rst deasserts, ready SHALL rise exactly NREGS cycles later.
REQ-032 There SHALL be no dependence on initial blocks; the behaviour SHALL be identical in synthesis and simulation.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-034 With REGFILE_BYPASS_EN defined, a read port addressing the register being written in the same cycle (accepted write, address != 0) SHALL return wr_data.
REQ-035 Without REGFILE_BYPASS_EN, such a read SHALL return the pre-write array value; the new value SHALL be visible from the next cycle.

Structure
REQ-036 Package regfile_pkg SHALL hold the state enum (CLEAR, RUN) and the default XLEN and NREGS constants.
REQ-037 Sub-module regfile_scoreboard SHALL own the busy-bit vector and its set, clear and priority rules.
REQ-038 The data array, read muxes, bypass and clear FSM SHALL remain in regfile_mp.

Verification
REQ-039 Default parameters, rst for 1 cycle -> ready=0 for 32 cycles, then 1; all reads return 0.
REQ-040 Write reg5=0x1234, then read reg5 on port 1 the next cycle -> 0x1234; write reg0=0xFF -> a read of reg0 returns 0.
REQ-041 Same-cycle write reg7=0xAA and read of reg7, where reg7 previously held 0x11 -> rd_data=0xAA with bypass, 0x11 without.
REQ-042 Alloc reg3, next cycle write reg3 -> rd_busy=1 for one cycle, then 0; alloc and write reg3 in the same cycle -> data written and busy=1.
REQ-043 Assert rst at clear index 10 -> counter restarts at 0 and ready rises 32 cycles after rst deasserts; a wr_en pulsed during the clear leaves its target at 0.
REQ-044 NREAD=4 with all ports reading reg9=0x55 -> all four ports return 0x55.
